// File: rtl/alien_spawner.sv
// Alien spawn pacer: draws one LFSR byte per spawn and offers position/lane over valid/ready.
// Optional interval ramp is compiled in with `define SPAWN_RAMP_EN.
module alien_spawner #(
    parameter int MAX_ALIENS    = 4,
    parameter int BASE_INTERVAL = 60,
    parameter int MIN_INTERVAL  = 16,
    parameter int X_MIN         = 32
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       game_active,
    input  logic [7:0] random,
    output logic       lfsr_en,
    input  logic       alien_killed,
    output logic       spawn_valid,
    input  logic       spawn_ready,
    output logic [9:0] spawn_x,
    output logic [1:0] spawn_lane,
    output logic [2:0] live_count
);

    typedef enum logic [1:0] {
        WAIT    = 2'd0,
        DRAW    = 2'd1,
        CAPTURE = 2'd2,
        OFFER   = 2'd3
    } state_t;

    localparam logic [7:0] BASE_L  = 8'(BASE_INTERVAL);
    localparam logic [7:0] MIN_L   = 8'(MIN_INTERVAL);
    localparam logic [9:0] X_MIN_L = 10'(X_MIN);
    localparam logic [2:0] MAX_L   = 3'(MAX_ALIENS);

`ifdef SPAWN_RAMP_EN
    localparam bit RAMP = 1'b1;
`else
    localparam bit RAMP = 1'b0;
`endif

    state_t     state;
    logic [7:0] count;
    logic [7:0] cur_interval;
    logic       accept;

    assign accept = spawn_valid && spawn_ready;

    // Shrink by 4 frames per spawn, clamped at the floor without wrapping.
    function automatic logic [7:0] ramp_next(input logic [7:0] cur);
        if ({1'b0, cur} >= ({1'b0, MIN_L} + 9'd4))
            return cur - 8'd4;
        return MIN_L;
    endfunction

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= WAIT;
            count        <= BASE_L;
            cur_interval <= BASE_L;
            lfsr_en      <= 1'b0;
            spawn_valid  <= 1'b0;
            spawn_x      <= 10'd0;
            spawn_lane   <= 2'd0;
            live_count   <= 3'd0;
        end else begin
            case (state)
                WAIT: begin
                    if (frame_tick && game_active) begin
                        if (count != 8'd0) begin
                            count <= count - 8'd1;
                        end else if (live_count < MAX_L) begin
                            state   <= DRAW;
                            lfsr_en <= 1'b1;
                        end
                    end
                end
                DRAW: begin
                    lfsr_en <= 1'b0;
                    state   <= CAPTURE;
                end
                CAPTURE: begin
                    // random has advanced by now; the reload uses the pre-ramp interval.
                    spawn_x     <= X_MIN_L + {1'b0, random, 1'b0};
                    spawn_lane  <= random[5:4];
                    count       <= cur_interval + {4'b0000, random[3:0]};
                    spawn_valid <= 1'b1;
                    state       <= OFFER;
                end
                OFFER: begin
                    if (spawn_ready) begin
                        spawn_valid <= 1'b0;
                        state       <= WAIT;
                        if (RAMP)
                            cur_interval <= ramp_next(cur_interval);
                    end
                end
                default: begin
                    state       <= WAIT;
                    lfsr_en     <= 1'b0;
                    spawn_valid <= 1'b0;
                end
            endcase

            // A kill and an accepted spawn on the same edge cancel out.
            if (accept && !alien_killed)
                live_count <= live_count + 3'd1;
            else if (!accept && alien_killed && (live_count != 3'd0))
                live_count <= live_count - 3'd1;
        end
    end

endmodule

// File: doc/alien_spawner.md
# alien_spawner

Paces alien spawns for the play field. Sits directly downstream of the 8-bit LFSR random source:
- Strobes the LFSR's enable for exactly one cycle per spawn.
- Captures the new random byte and turns it into a spawn position, lane and jittered next-spawn delay.
- Offers the spawn to the alien object manager over a valid/ready handshake.
- Tracks live aliens and never exceeds MAX_ALIENS.

## Interface
Parameters:
- MAX_ALIENS, 4, cap on live aliens; legal 1..7
- BASE_INTERVAL, 60, frames between spawns after reset; legal 1..240
- MIN_INTERVAL, 16, interval floor when ramp is compiled in; legal 1..BASE_INTERVAL
- X_MIN, 32, left edge of spawn region in pixels

Ports:
- Clk  in  1  system clock; one clock
- Reset  in  1  asynchronous, active-high; clears all state immediately
- frame_tick  in  1  one-cycle pulse per video frame
- game_active  in  1  high while play is running
- random  in  8  LFSR output
- lfsr_en  out  1  enable to LFSR; high one cycle per draw
- alien_killed  in  1  one-cycle pulse, one alien removed
- spawn_valid  out  1  spawn offer valid
- spawn_ready  in  1  object manager accepts offer
- spawn_x  out  10  spawn x pixel
- spawn_lane  out  2  spawn lane index
- live_count  out  3  current live aliens

## Operation
- States: WAIT, DRAW, CAPTURE, OFFER. Reset state is WAIT.
- Registers:
  - count: 8 bit.
  - cur_interval: 8 bit.
- Reset values:
  - count=BASE_INTERVAL, cur_interval=BASE_INTERVAL.
  - All outputs 0.
- WAIT:
  - Acts only on frame_tick && game_active; otherwise count holds.
  - If count≠0: count decrements.
  - If count==0 and live_count<MAX_ALIENS: go to DRAW.
  - If count==0 and full: stay in WAIT with count at 0; retry on each later qualifying tick.
- DRAW: lfsr_en=1 for this single cycle; next state CAPTURE.
- CAPTURE (on exit edge), from captured byte r=random:
  - spawn_x = X_MIN + {r,1'b0} (10-bit, no wrap for X_MIN≤513).
  - spawn_lane = r[5:4].
  - count = cur_interval + r[3:0].
  - Next state OFFER.
- OFFER:
  - spawn_valid=1; spawn_x and spawn_lane held stable until accepted.
  - spawn_valid && spawn_ready at an edge completes the transfer: live_count+1, state WAIT.
  - Transfer is not abandoned if game_active falls.
- game_active gates only WAIT; DRAW, CAPTURE and OFFER always complete.
- live_count:
  - Accepted spawn and alien_killed on the same edge: net unchanged.
  - alien_killed at live_count==0: ignored, no underflow.
  - Saturation is impossible by construction (spawn only when <MAX).
- frame_tick outside WAIT is ignored (not queued).
- Reset asserted mid-OFFER: spawn_valid drops asynchronously, no transfer counted.

## Timing
- Qualifying frame_tick sampled at edge N with count==0 → DRAW after N.
- lfsr_en high in cycle N..N+1; LFSR advances at edge N+1.
- CAPTURE samples the advanced byte at edge N+2.
- spawn_valid high after N+2; earliest accept at edge N+3.
- From reset with game_active=1, first DRAW follows the (BASE_INTERVAL+1)th frame_tick.
- Subsequent spawns need reload+1 qualifying ticks after CAPTURE, plus handshake wait.
- lfsr_en is never high outside DRAW, so the LFSR advances exactly once per spawn.

## Configuration
- SPAWN_RAMP_EN defined:
  - On each accepted spawn, cur_interval = max(cur_interval−4, MIN_INTERVAL).
  - The update uses the pre-update value; no underflow below MIN_INTERVAL.
  - The reload computed in CAPTURE uses cur_interval as it stood before that spawn's decrement.
- Not defined: cur_interval fixed at BASE_INTERVAL; MIN_INTERVAL unused.

## Test plan
(BASE_INTERVAL=3, MAX_ALIENS=2, X_MIN=32, real LFSR attached, spawn_ready=1 unless stated.)
- Reset then game_active=1, frame_ticks:
  - 4th tick → lfsr_en pulse one cycle, random 8'h01.
  - spawn_valid two edges later with spawn_x=34, spawn_lane=0.
  - count reload 4; live_count=1 after accept.
- Continue ticks:
  - 5 ticks after first CAPTURE → second draw, random 8'h03, spawn_x=38, reload 6.
  - live_count=2.
  - Further count expiry holds in WAIT, no lfsr_en.
  - alien_killed pulse → next qualifying tick draws 8'h07.
- spawn_ready=0 in OFFER for 10 cycles:
  - spawn_valid, spawn_x, spawn_lane stable; no second lfsr_en.
  - Accept on ready rise; live_count increments once.
- Accept and alien_killed on same edge → live_count unchanged; alien_killed at 0 → stays 0.
- game_active=0 during WAIT → count frozen across 5 ticks; Reset asserted mid-OFFER → spawn_valid=0 and live_count=0 before next Clk edge.
- With SPAWN_RAMP_EN, BASE_INTERVAL=24, MIN_INTERVAL=16:
  - cur_interval after successive accepts: 20, 16, 16.
  - Without the macro: stays 24.
